position_arbiter: RTL

POSITION_ARBITER -- requirements
Module: position_arbiter

---
 rtl/position_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/position_arbiter.sv
// Two-requester round-robin arbiter in front of one shared position-update unit.
// Every soc/eoc pair is a four-phase handshake; all handshake outputs decode from state/sel only.
module position_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       soc_a,
  output logic       eoc_a,
  input  logic       soc_b,
  output logic       eoc_b,
  output logic [7:0] xa,
  output logic [7:0] ya,
  output logic [7:0] xb,
  output logic [7:0] yb,
  output logic [7:0] cnt_a,
  output logic [7:0] cnt_b,
  output logic       soc_p,
  input  logic       eoc_p,
  input  logic [7:0] x_p,
  input  logic [7:0] y_p,
  output logic       busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic [1:0] state;
  logic       sel;
  logic       last;
  logic       soc_sel;
  logic       active;

  assign soc_sel = (sel == SEL_B) ? soc_b : soc_a;
  // The selected requester sees eoc low from START through RUN; DONE raises it again.
  assign active  = (state == START) || (state == RUN);
  assign soc_p   = (state == START);
  assign busy    = (state != IDLE);
  assign eoc_a   = !(active && (sel == SEL_A));
  assign eoc_b   = !(active && (sel == SEL_B));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel   <= SEL_A;
      last  <= SEL_B;
      xa    <= '0;
      ya    <= '0;
      xb    <= '0;
      yb    <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (soc_a && soc_b) begin
            sel   <= ~last;
            state <= START;
          end else if (soc_a) begin
            sel   <= SEL_A;
            state <= START;
          end else if (soc_b) begin
            sel   <= SEL_B;
            state <= START;
          end
        end
        START: begin
          if (!eoc_p) state <= RUN;
        end
        RUN: begin
          // Result is only taken once the requester has dropped soc.
          if (eoc_p && !soc_sel) begin
            if (sel == SEL_A) begin
              xa    <= x_p;
              ya    <= y_p;
              cnt_a <= cnt_a + 8'd1;
            end else begin
              xb    <= x_p;
              yb    <= y_p;
              cnt_b <= cnt_b + 8'd1;
            end
            state <= DONE;
          end
        end
        default: begin
          last  <= sel;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
